aura_mem_responder: RTL and testbench

//  Memory-side responder for the accelerator's tagged main-memory protocol: consumes proc2mem_* from

---
 rtl/sys_defs.sv | 15 +
 rtl/aura_mem_tag_alloc.sv | 47 ++++
 rtl/aura_mem_responder.sv | 111 +++++++++++
 tb/tb_aura_mem_responder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared definitions for the tagged main-memory protocol between memory_controller and the memory side.
package sys_defs;
   localparam int NUM_MEM_TAGS = 15;
   localparam int MEM_LATENCY  = 8;

   typedef logic [3:0]  MEM_TAG;
   typedef logic [63:0] MEM_BLOCK;
   typedef logic [31:0] ADDR;

   typedef enum logic [1:0] {
      MEM_NONE  = 2'h0,
      MEM_LOAD  = 2'h1,
      MEM_STORE = 2'h2
   } MEM_COMMAND;
endpackage

// File: rtl/aura_mem_tag_alloc.sv
// Transaction tag pool: busy vector, lowest-free-tag priority encoder, alloc/free strobes.
module aura_mem_tag_alloc
   import sys_defs::*;
#(
   parameter int NUM_TAGS = NUM_MEM_TAGS
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            alloc_en,
   input  logic                            free_en,
   input  MEM_TAG                          free_tag,
   output MEM_TAG                          alloc_tag,
   output logic [NUM_TAGS:1]               busy,
   output logic [$clog2(NUM_TAGS+1)-1:0]   free_cnt
);
   localparam int FCW = $clog2(NUM_TAGS + 1);

   logic [NUM_TAGS:1] busy_nxt;

   // Descending scan so the lowest-numbered free tag wins; 0 means none free.
   always_comb begin
      alloc_tag = '0;
      for (int i = NUM_TAGS; i >= 1; i--) begin
         if (!busy[i]) alloc_tag = MEM_TAG'(i);
      end
   end

   always_comb begin
      busy_nxt = busy;
      for (int i = 1; i <= NUM_TAGS; i++) begin
         if (free_en && (free_tag == MEM_TAG'(i)))   busy_nxt[i] = 1'b0;
         if (alloc_en && (alloc_tag == MEM_TAG'(i))) busy_nxt[i] = 1'b1;
      end
   end

   always_comb begin
      free_cnt = '0;
      for (int i = 1; i <= NUM_TAGS; i++) begin
         free_cnt = free_cnt + FCW'(!busy[i]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) busy <= '0;
      else      busy <= busy_nxt;
   end
endmodule

// File: rtl/aura_mem_responder.sv
// Memory-side responder: same-cycle load tag, load data returned with its tag a fixed LATENCY later.
module aura_mem_responder
   import sys_defs::*;
#(
   parameter int NUM_TAGS  = NUM_MEM_TAGS,
   parameter int LATENCY   = MEM_LATENCY,
   parameter int MEM_WORDS = 4096
) (
   input  logic       clk,
   input  logic       rst,
   input  MEM_COMMAND proc2mem_command,
   input  ADDR        proc2mem_addr,
   input  MEM_BLOCK   proc2mem_data,
   output MEM_TAG     mem2proc_transaction_tag,
   output MEM_BLOCK   mem2proc_data,
   output MEM_TAG     mem2proc_data_tag
);
   localparam int AW  = $clog2(MEM_WORDS);
   localparam int PD  = LATENCY - 1;
   localparam int FCW = $clog2(NUM_TAGS + 1);

   logic [63:0]       mem [MEM_WORDS];
   logic [AW-1:0]     word_idx;
   logic              unused_addr_bits;
   logic              is_load;
   logic              is_store;
   logic              load_acc;
   MEM_TAG            alloc_tag;
   logic [NUM_TAGS:1] busy;
   logic [FCW-1:0]    free_cnt;
   logic              vld_p  [PD];
   MEM_TAG            tag_p  [PD];
   MEM_BLOCK          data_p [PD];

   // Upper address bits alias; the byte offset within a block is irrelevant.
   assign word_idx         = proc2mem_addr[3 +: AW];
   assign unused_addr_bits = ^{proc2mem_addr[31:3+AW], proc2mem_addr[2:0]};

   assign is_load  = rst && (proc2mem_command == MEM_LOAD);
   assign is_store = rst && (proc2mem_command == MEM_STORE);
   assign load_acc = is_load && (alloc_tag != '0);
   assign mem2proc_transaction_tag = is_load ? alloc_tag : '0;

   aura_mem_tag_alloc #(.NUM_TAGS(NUM_TAGS)) u_tag_alloc (
      .clk       (clk),
      .rst       (rst),
      .alloc_en  (is_load),
      .free_en   (mem2proc_data_tag != '0),
      .free_tag  (mem2proc_data_tag),
      .alloc_tag (alloc_tag),
      .busy      (busy),
      .free_cnt  (free_cnt)
   );

   always_ff @(posedge clk) begin
      if (is_store) mem[word_idx] <= proc2mem_data;
   end

   // Stage 0 captures load data in the accept cycle, so later stores cannot disturb it.
   always_ff @(posedge clk) begin
      data_p[0] <= mem[word_idx];
      for (int i = 1; i < PD; i++) data_p[i] <= data_p[i-1];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < PD; i++) begin
            vld_p[i] <= 1'b0;
            tag_p[i] <= '0;
         end
      end else begin
         vld_p[0] <= load_acc;
         tag_p[0] <= load_acc ? alloc_tag : '0;
         for (int i = 1; i < PD; i++) begin
            vld_p[i] <= vld_p[i-1];
            tag_p[i] <= tag_p[i-1];
         end
      end
   end

   // Output stage: the LATENCY-th register after the accept edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem2proc_data_tag <= '0;
         mem2proc_data     <= '0;
      end else begin
         mem2proc_data_tag <= vld_p[PD-1] ? tag_p[PD-1] : '0;
         mem2proc_data     <= vld_p[PD-1] ? data_p[PD-1] : '0;
      end
   end

`ifndef SYNTHESIS
   logic [NUM_TAGS:0] busy_ext;
   int                in_flight;

   assign busy_ext = {busy, 1'b0};

   always_comb begin
      in_flight = (mem2proc_data_tag != '0) ? 1 : 0;
      for (int i = 0; i < PD; i++) in_flight = in_flight + (vld_p[i] ? 1 : 0);
   end

   always @(posedge clk) begin
      if (rst) begin
         assert (mem2proc_data_tag == '0 || busy_ext[mem2proc_data_tag]);
         assert (!load_acc || !busy_ext[alloc_tag]);
         assert (int'(free_cnt) + in_flight == NUM_TAGS);
      end
   end
`endif
endmodule

// File: tb/tb_aura_mem_responder.sv
// Directed bench for aura_mem_responder: vector table plus hand-written multi-cycle sequences.
module tb_aura_mem_responder;
   import sys_defs::*;

   localparam int NT  = 15;
   localparam int LAT = 16;
   localparam int MW  = 4096;

   typedef struct {
      MEM_COMMAND cmd;
      ADDR        addr;
      MEM_BLOCK   data;
      MEM_TAG     exp_tag;
      MEM_BLOCK   exp_rsp;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   MEM_COMMAND cmd;
   ADDR        addr;
   MEM_BLOCK   wdata;
   MEM_TAG     ttag;
   MEM_TAG     dtag;
   MEM_BLOCK   rdata;
   int         checks = 0;
   int         errors = 0;
   vec_t       vecs [12];

   always #5 clk = ~clk;

   aura_mem_responder #(.NUM_TAGS(NT), .LATENCY(LAT), .MEM_WORDS(MW)) dut (
      .clk                      (clk),
      .rst                      (rst),
      .proc2mem_command         (cmd),
      .proc2mem_addr            (addr),
      .proc2mem_data            (wdata),
      .mem2proc_transaction_tag (ttag),
      .mem2proc_data            (rdata),
      .mem2proc_data_tag        (dtag)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk_rsp(input string name, input MEM_TAG et, input MEM_BLOCK ed);
      check({name, " data_tag"}, 64'(dtag), 64'(et));
      check({name, " data"}, rdata, ed);
   endtask

   // One bus cycle: drive just after the rising edge, return at the falling edge for sampling.
   task automatic cyc(input MEM_COMMAND c, input ADDR a, input MEM_BLOCK d);
      @(posedge clk);
      #1;
      cmd   = c;
      addr  = a;
      wdata = d;
      @(negedge clk);
   endtask

   initial begin
      int et;
      int ed;

      vecs[0]  = '{MEM_STORE, 32'h0000_0100, 64'hDEADBEEF_CAFEF00D, 4'd0, 64'h0};
      vecs[1]  = '{MEM_LOAD,  32'h0000_0100, 64'h0, 4'd1, 64'hDEADBEEF_CAFEF00D};
      vecs[2]  = '{MEM_STORE, 32'h0000_0008, 64'h55, 4'd0, 64'h0};
      vecs[3]  = '{MEM_LOAD,  32'h0000_8008, 64'h0, 4'd1, 64'h55};
      vecs[4]  = '{MEM_LOAD,  32'h0000_000F, 64'h0, 4'd1, 64'h55};
      vecs[5]  = '{MEM_STORE, 32'h0000_000F, 64'h66, 4'd0, 64'h0};
      vecs[6]  = '{MEM_LOAD,  32'h0000_0008, 64'h0, 4'd1, 64'h66};
      vecs[7]  = '{MEM_NONE,  32'h0000_0008, 64'h99, 4'd0, 64'h0};
      vecs[8]  = '{MEM_COMMAND'(2'd3), 32'h0000_0008, 64'h77, 4'd0, 64'h0};
      vecs[9]  = '{MEM_LOAD,  32'h0000_0008, 64'h0, 4'd1, 64'h66};
      vecs[10] = '{MEM_STORE, 32'h0010_0100, 64'h1234, 4'd0, 64'h0};
      vecs[11] = '{MEM_LOAD,  32'h0000_0100, 64'h0, 4'd1, 64'h1234};

      cmd   = MEM_NONE;
      addr  = '0;
      wdata = '0;

      // Reset with a load pending: everything quiet.
      repeat (2) @(posedge clk);
      #1;
      cmd  = MEM_LOAD;
      addr = 32'h40;
      @(negedge clk);
      check("por ttag", 64'(ttag), 64'h0);
      chk_rsp("por", 4'd0, 64'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      cmd = MEM_NONE;

      // Put three loads in flight, then reset underneath them.
      cyc(MEM_LOAD, 32'h40, 64'h0);
      check("pre ld0 ttag", 64'(ttag), 64'h1);
      cyc(MEM_LOAD, 32'h48, 64'h0);
      check("pre ld1 ttag", 64'(ttag), 64'h2);
      cyc(MEM_LOAD, 32'h50, 64'h0);
      check("pre ld2 ttag", 64'(ttag), 64'h3);
      cyc(MEM_NONE, 32'h0, 64'h0);
      cyc(MEM_NONE, 32'h0, 64'h0);
      @(posedge clk);
      #1;
      rst  = 1'b0;
      cmd  = MEM_LOAD;
      addr = 32'h40;
      @(negedge clk);
      check("midrst ttag", 64'(ttag), 64'h0);
      chk_rsp("midrst", 4'd0, 64'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      cmd = MEM_NONE;
      @(negedge clk);
      cyc(MEM_LOAD, 32'h40, 64'h0);
      check("postrst ttag", 64'(ttag), 64'h1);
      for (int k = 1; k <= LAT + 4; k++) begin
         cyc(MEM_NONE, 32'h0, 64'h0);
         check($sformatf("postrst c%0d data_tag", k), 64'(dtag), (k == LAT) ? 64'h1 : 64'h0);
         if (k != LAT) check($sformatf("postrst c%0d data", k), rdata, 64'h0);
      end

      // Single-transaction vector table.
      for (int v = 0; v < 12; v++) begin
         cyc(vecs[v].cmd, vecs[v].addr, vecs[v].data);
         check($sformatf("vec%0d ttag", v), 64'(ttag), 64'(vecs[v].exp_tag));
         chk_rsp($sformatf("vec%0d issue", v), 4'd0, 64'h0);
         if (vecs[v].cmd == MEM_LOAD) begin
            for (int k = 1; k <= LAT + 1; k++) begin
               cyc(MEM_NONE, 32'h0, 64'h0);
               if (k == LAT) chk_rsp($sformatf("vec%0d rsp", v), vecs[v].exp_tag, vecs[v].exp_rsp);
               else          chk_rsp($sformatf("vec%0d c%0d", v, k), 4'd0, 64'h0);
            end
         end
      end

      // Back-to-back loads, responses on consecutive cycles in order.
      cyc(MEM_STORE, 32'h0,  64'd1);
      cyc(MEM_STORE, 32'h8,  64'd2);
      cyc(MEM_STORE, 32'h10, 64'd3);
      for (int i = 0; i < 3; i++) begin
         cyc(MEM_LOAD, ADDR'(i * 8), 64'h0);
         check($sformatf("b2b ld%0d ttag", i), 64'(ttag), 64'(i + 1));
      end
      for (int k = 3; k <= LAT + 3; k++) begin
         cyc(MEM_NONE, 32'h0, 64'h0);
         et = (k >= LAT && k <= LAT + 2) ? (k - LAT + 1) : 0;
         chk_rsp($sformatf("b2b c%0d", k), MEM_TAG'(et), MEM_BLOCK'(et));
      end

      // Tag exhaustion, rejection in the response cycle, reuse in the following cycle.
      for (int c = 0; c <= 35; c++) begin
         cyc((c <= 17) ? MEM_LOAD : MEM_NONE, 32'h0, 64'h0);
         if (c < 15)       et = c + 1;
         else if (c == 17) et = 1;
         else              et = 0;
         check($sformatf("full c%0d ttag", c), 64'(ttag), 64'(et));
         if (c >= 16 && c <= 30) et = c - 15;
         else if (c == 33)       et = 1;
         else                    et = 0;
         ed = (et != 0) ? 1 : 0;
         chk_rsp($sformatf("full c%0d", c), MEM_TAG'(et), MEM_BLOCK'(ed));
      end

      // Store behind a pending load must not change that load's data.
      cyc(MEM_STORE, 32'h200, 64'hAA);
      cyc(MEM_LOAD, 32'h200, 64'h0);
      check("haz ld ttag", 64'(ttag), 64'h1);
      cyc(MEM_STORE, 32'h200, 64'hBB);
      check("haz st ttag", 64'(ttag), 64'h0);
      for (int c = 2; c <= LAT + 1; c++) begin
         cyc(MEM_NONE, 32'h0, 64'h0);
         if (c == LAT) chk_rsp("haz rsp", 4'd1, 64'hAA);
         else          chk_rsp($sformatf("haz c%0d", c), 4'd0, 64'h0);
      end
      cyc(MEM_LOAD, 32'h200, 64'h0);
      check("haz ld2 ttag", 64'(ttag), 64'h1);
      for (int k = 1; k <= LAT + 1; k++) begin
         cyc(MEM_NONE, 32'h0, 64'h0);
         if (k == LAT) chk_rsp("haz rsp2", 4'd1, 64'hBB);
         else          chk_rsp($sformatf("haz2 c%0d", k), 4'd0, 64'h0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
